// File: rtl/menu_pkg.sv
// rtl/menu_pkg.sv - scancode constants and shared enums for the front-panel menu.
package menu_pkg;

  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_BKSP  = 8'h66;

  // Element i is the set-2 make code of decimal digit i.
  localparam logic [9:0][7:0] SC_DIGITS = {
    8'h46, 8'h3E, 8'h3D, 8'h36, 8'h2E, 8'h25, 8'h26, 8'h1E, 8'h16, 8'h45
  };

  typedef enum logic [2:0] {
    EV_NONE, EV_LEFT, EV_RIGHT, EV_ENTER, EV_ESC, EV_BKSP, EV_DIGIT
  } key_ev_t;

  typedef enum logic {
    NAV, EDIT
  } menu_state_t;

endpackage

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 set-2 prefix FSM and key map.
// Events are combinational so the menu registers them on the same edge as the final byte.
module ps2_key_decoder
  import menu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       kb_valid,
  input  logic [7:0] kb_byte,
  output logic       ev_valid,
  output key_ev_t    ev_code,
  output logic [3:0] ev_digit
);

  typedef enum logic [1:0] {D_IDLE, D_EXT, D_BRK, D_EXTBRK} dec_state_t;

  dec_state_t state, state_n;

  always_ff @(posedge clk) begin
    if (rst) state <= D_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    ev_valid = 1'b0;
    ev_code  = EV_NONE;
    ev_digit = 4'h0;
    if (kb_valid) begin
      case (state)
        D_IDLE: begin
          if (kb_byte == SC_E0)      state_n = D_EXT;
          else if (kb_byte == SC_F0) state_n = D_BRK;
          else begin
            state_n = D_IDLE;
            if (kb_byte == SC_ENTER)     begin ev_valid = 1'b1; ev_code = EV_ENTER; end
            else if (kb_byte == SC_ESC)  begin ev_valid = 1'b1; ev_code = EV_ESC;   end
            else if (kb_byte == SC_BKSP) begin ev_valid = 1'b1; ev_code = EV_BKSP;  end
            for (int i = 0; i < 10; i++) begin
              if (kb_byte == SC_DIGITS[i]) begin
                ev_valid = 1'b1;
                ev_code  = EV_DIGIT;
                ev_digit = 4'(i);
              end
            end
          end
        end
        D_EXT: begin
          if (kb_byte == SC_F0) state_n = D_EXTBRK;
          else begin
            state_n = D_IDLE;
            if (kb_byte == SC_LEFT)       begin ev_valid = 1'b1; ev_code = EV_LEFT;  end
            else if (kb_byte == SC_RIGHT) begin ev_valid = 1'b1; ev_code = EV_RIGHT; end
          end
        end
        default: state_n = D_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/menu_selector.sv
// rtl/menu_selector.sv - keyboard-driven button/numeric-field menu for the VGA panel.
// Optional edit idle timeout is built when MENU_TIMEOUT_EN is defined.
module menu_selector
  import menu_pkg::*;
#(
  parameter int                 N_BTN          = 3,
  parameter int                 DIGITS         = 5,
  parameter logic [4*DIGITS-1:0] DEFAULT_BCD   = 20'h10000,
  parameter logic [31:0]        TIMEOUT_CYCLES = 32'd800_000_000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          kb_valid,
  input  logic [7:0]                    kb_byte,
  output logic [$clog2(N_BTN+1)-1:0]    focus,
  output logic [N_BTN-1:0]              btn_pulse,
  output logic                          edit_active,
  output logic [4*DIGITS-1:0]           edit_bcd,
  output logic [4*DIGITS-1:0]           value_bcd,
  output logic [8*DIGITS-1:0]           value_ascii,
  output logic                          value_commit,
  output logic                          entry_error
);

  localparam int FW = $clog2(N_BTN+1);
  localparam int W  = 4*DIGITS;
  localparam logic [FW-1:0] LAST = FW'(N_BTN);

  function automatic logic [8*DIGITS-1:0] to_ascii(input logic [W-1:0] b);
    logic [8*DIGITS-1:0] a;
    a = '0;
    for (int i = 0; i < DIGITS; i++) a[8*i +: 8] = {4'h3, b[4*i +: 4]};
    return a;
  endfunction

  logic       ev_valid;
  key_ev_t    ev_code;
  logic [3:0] ev_digit;
  logic       timeout_hit;

  ps2_key_decoder u_dec (
    .clk      (clk),
    .rst      (rst),
    .kb_valid (kb_valid),
    .kb_byte  (kb_byte),
    .ev_valid (ev_valid),
    .ev_code  (ev_code),
    .ev_digit (ev_digit)
  );

  menu_state_t     state, state_n;
  logic [FW-1:0]   focus_n;
  logic [N_BTN-1:0] pulse_n;
  logic [W-1:0]    edit_n, value_n;
  logic            commit_n, error_n;

`ifdef MENU_TIMEOUT_EN
  logic [31:0] idle_cnt;

  // Idle time since entering EDIT or the last key event there.
  always_ff @(posedge clk) begin
    if (rst || state == NAV || ev_valid) idle_cnt <= '0;
    else                                 idle_cnt <= idle_cnt + 32'd1;
  end

  assign timeout_hit = (state == EDIT) && (idle_cnt == TIMEOUT_CYCLES - 32'd1);
`else
  assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES == 32'd0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= NAV;
      focus        <= '0;
      btn_pulse    <= '0;
      edit_bcd     <= DEFAULT_BCD;
      value_bcd    <= DEFAULT_BCD;
      value_ascii  <= to_ascii(DEFAULT_BCD);
      value_commit <= 1'b0;
      entry_error  <= 1'b0;
    end else begin
      state        <= state_n;
      focus        <= focus_n;
      btn_pulse    <= pulse_n;
      edit_bcd     <= edit_n;
      value_bcd    <= value_n;
      value_ascii  <= to_ascii(value_n);
      value_commit <= commit_n;
      entry_error  <= error_n;
    end
  end

  assign edit_active = (state == EDIT);

  always_comb begin
    state_n  = state;
    focus_n  = focus;
    pulse_n  = '0;
    edit_n   = edit_bcd;
    value_n  = value_bcd;
    commit_n = 1'b0;
    error_n  = 1'b0;
    case (state)
      NAV: begin
        if (ev_valid) begin
          case (ev_code)
            EV_LEFT:  focus_n = (focus == '0) ? LAST : focus - FW'(1);
            EV_RIGHT: focus_n = (focus == LAST) ? '0 : focus + FW'(1);
            EV_ENTER: begin
              if (focus < LAST) pulse_n = N_BTN'(1) << focus;
              else begin
                state_n = EDIT;
                edit_n  = value_bcd;
              end
            end
            default: ;
          endcase
        end
      end
      EDIT: begin
        if (ev_valid) begin
          case (ev_code)
            EV_DIGIT: edit_n = {edit_bcd[W-5:0], ev_digit};
            EV_BKSP:  edit_n = {4'h0, edit_bcd[W-1:4]};
            EV_ENTER: begin
              if (edit_bcd != '0) begin
                value_n  = edit_bcd;
                commit_n = 1'b1;
                state_n  = NAV;
              end else error_n = 1'b1;
            end
            EV_ESC: begin
              edit_n  = value_bcd;
              state_n = NAV;
            end
            default: ;
          endcase
        end else if (timeout_hit) begin
          edit_n  = value_bcd;
          state_n = NAV;
        end
      end
      default: state_n = NAV;
    endcase
  end

endmodule

// File: tb/tb_menu_selector.sv
// tb/tb_menu_selector.sv - directed bench for menu_selector with a digit-array reference model.
module tb_menu_selector;

  localparam int N  = 3;
  localparam int D  = 5;
  localparam int T  = 100;
  localparam logic [19:0] DEF = 20'h10000;

  logic        clk = 1'b0;
  logic        rst;
  logic        kb_valid;
  logic [7:0]  kb_byte;
  logic [1:0]  focus;
  logic [2:0]  btn_pulse;
  logic        edit_active;
  logic [19:0] edit_bcd, value_bcd;
  logic [39:0] value_ascii;
  logic        value_commit, entry_error;

  menu_selector #(.N_BTN(N), .DIGITS(D), .DEFAULT_BCD(DEF), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .kb_valid(kb_valid), .kb_byte(kb_byte),
    .focus(focus), .btn_pulse(btn_pulse), .edit_active(edit_active),
    .edit_bcd(edit_bcd), .value_bcd(value_bcd), .value_ascii(value_ascii),
    .value_commit(value_commit), .entry_error(entry_error)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] dig_code [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] pq[$];
  int  m_val [D];
  int  m_ed  [D];
  int  m_focus, m_last, cyc;
  bit  m_edit, m_commit, m_err, m_ready;
  logic [2:0] m_pulse;

  function automatic logic [19:0] pack(input int a [D]);
    logic [19:0] r = '0;
    for (int i = 0; i < D; i++) r = {r[15:0], 4'(a[i])};
    return r;
  endfunction

  function automatic logic [39:0] asc(input int a [D]);
    logic [39:0] r = '0;
    for (int i = 0; i < D; i++) r = {r[31:0], 8'(8'h30 + a[i])};
    return r;
  endfunction

  // key: 0 none, 1 left, 2 right, 3 enter, 4 esc, 5 bksp, 6 digit
  task automatic decode_byte(input logic [7:0] b, output int key, output int dig);
    bit brk;
    key = 0; dig = 0;
    pq.push_back(b);
    if ((pq.size() == 1 && (b == 8'hE0 || b == 8'hF0)) ||
        (pq.size() == 2 && pq[0] == 8'hE0 && b == 8'hF0)) return;
    brk = 0;
    foreach (pq[i]) if (pq[i] == 8'hF0) brk = 1;
    if (!brk) begin
      if (pq.size() == 2) begin
        if (b == 8'h6B) key = 1;
        if (b == 8'h74) key = 2;
      end else begin
        if (b == 8'h5A) key = 3;
        if (b == 8'h76) key = 4;
        if (b == 8'h66) key = 5;
        for (int i = 0; i < 10; i++) if (b == dig_code[i]) begin key = 6; dig = i; end
      end
    end
    pq.delete();
  endtask

  always @(posedge clk) begin
    int key, dig;
    bit nz;
    cyc++;
    m_pulse = 0; m_commit = 0; m_err = 0;
    if (rst) begin
      m_ready = 1; m_edit = 0; m_focus = 0; pq.delete();
      for (int i = 0; i < D; i++) m_val[i] = int'((DEF >> (4*(D-1-i))) & 20'hF);
      m_ed = m_val;
    end else begin
      key = 0; dig = 0;
      if (kb_valid) decode_byte(kb_byte, key, dig);
      if (!m_edit) begin
        if (key == 1) m_focus = (m_focus == 0) ? N : m_focus - 1;
        if (key == 2) m_focus = (m_focus == N) ? 0 : m_focus + 1;
        if (key == 3) begin
          if (m_focus < N) m_pulse = 3'(1 << m_focus);
          else begin m_edit = 1; m_ed = m_val; m_last = cyc; end
        end
      end else if (key != 0) begin
        m_last = cyc;
        if (key == 6) begin
          for (int i = 0; i < D-1; i++) m_ed[i] = m_ed[i+1];
          m_ed[D-1] = dig;
        end
        if (key == 5) begin
          for (int i = D-1; i > 0; i--) m_ed[i] = m_ed[i-1];
          m_ed[0] = 0;
        end
        if (key == 3) begin
          nz = 0;
          foreach (m_ed[i]) if (m_ed[i] != 0) nz = 1;
          if (nz) begin m_val = m_ed; m_commit = 1; m_edit = 0; end
          else m_err = 1;
        end
        if (key == 4) begin m_ed = m_val; m_edit = 0; end
      end
`ifdef MENU_TIMEOUT_EN
      else if (cyc - m_last == T) begin m_ed = m_val; m_edit = 0; end
`endif
    end
  end

  always @(negedge clk) begin
    if (m_ready) begin
      chk("cmp focus",       {62'd0, focus},  64'(m_focus));
      chk("cmp btn_pulse",   {61'd0, btn_pulse}, {61'd0, m_pulse});
      chk("cmp edit_active", {63'd0, edit_active}, {63'd0, m_edit});
      chk("cmp edit_bcd",    {44'd0, edit_bcd},  {44'd0, pack(m_ed)});
      chk("cmp value_bcd",   {44'd0, value_bcd}, {44'd0, pack(m_val)});
      chk("cmp value_ascii", {24'd0, value_ascii}, {24'd0, asc(m_val)});
      chk("cmp commit",      {63'd0, value_commit}, {63'd0, m_commit});
      chk("cmp error",       {63'd0, entry_error},  {63'd0, m_err});
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] b);
    kb_valid = 1'b1; kb_byte = b;
    @(negedge clk);
    kb_valid = 1'b0; kb_byte = 8'h00;
  endtask

  task automatic right();
    send(8'hE0); send(8'h74);
  endtask

  task automatic left();
    send(8'hE0); send(8'h6B);
  endtask

  int   exp_focus [4] = '{1, 2, 3, 0};
  logic [7:0] tail [14] = '{8'hE0, 8'hF0, 8'h74, 8'hE0, 8'hE0, 8'h74, 8'hF0,
                            8'hF0, 8'h5A, 8'h45, 8'h46, 8'h3D, 8'h5A, 8'h00};
  logic exp_after_idle;

  initial begin
    rst = 1'b1; kb_valid = 1'b0; kb_byte = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset focus", {62'd0, focus}, 64'd0);
    chk("reset value_bcd", {44'd0, value_bcd}, 64'h10000);
    chk("reset value_ascii", {24'd0, value_ascii}, 64'h3130303030);
    chk("reset edit_bcd", {44'd0, edit_bcd}, 64'h10000);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      right();
      chk("right wrap focus", {62'd0, focus}, 64'(exp_focus[i]));
    end
    left();
    chk("left wrap focus", {62'd0, focus}, 64'd3);

    right(); right();
    send(8'h5A);
    chk("press btn1", {61'd0, btn_pulse}, 64'b010);
    @(negedge clk);
    chk("press btn1 ends", {61'd0, btn_pulse}, 64'd0);
    send(8'hF0); send(8'h5A);
    chk("break no pulse", {61'd0, btn_pulse}, 64'd0);

    right(); right();
    send(8'h5A);
    chk("edit entered", {63'd0, edit_active}, 64'd1);
    send(8'h16); chk("edit 00001", {44'd0, edit_bcd}, 64'h00001);
    send(8'h1E); chk("edit 00012", {44'd0, edit_bcd}, 64'h00012);
    send(8'h26); chk("edit 00123", {44'd0, edit_bcd}, 64'h00123);
    right();     chk("edit focus held", {62'd0, focus}, 64'd3);
    send(8'h5A);
    chk("commit pulse", {63'd0, value_commit}, 64'd1);
    chk("commit value", {44'd0, value_bcd}, 64'h00123);
    chk("commit ascii", {24'd0, value_ascii}, 64'h3030313233);
    chk("commit leaves edit", {63'd0, edit_active}, 64'd0);

    send(8'h5A);
    send(8'h66); send(8'h66); send(8'h66);
    chk("bksp to zero", {44'd0, edit_bcd}, 64'h0);
    send(8'h5A);
    chk("zero rejected", {63'd0, entry_error}, 64'd1);
    chk("still editing", {63'd0, edit_active}, 64'd1);
    send(8'h76);
    chk("esc restores", {44'd0, edit_bcd}, 64'h00123);
    chk("esc leaves edit", {63'd0, edit_active}, 64'd0);

    send(8'h16); send(8'h76); send(8'h66);
    chk("nav ignores digits", {44'd0, value_bcd}, 64'h00123);

    send(8'h5A); send(8'h16);
    chk("edit 01231", {44'd0, edit_bcd}, 64'h01231);
    send(8'hE0);
    rst = 1'b1; kb_valid = 1'b1; kb_byte = 8'h16;
    @(negedge clk);
    rst = 1'b0; kb_valid = 1'b0; kb_byte = 8'h00;
    chk("rst value", {44'd0, value_bcd}, 64'h10000);
    chk("rst edit_active", {63'd0, edit_active}, 64'd0);
    chk("rst focus", {62'd0, focus}, 64'd0);
    send(8'h74);
    chk("decoder idle after rst", {62'd0, focus}, 64'd0);
    send(8'h6B);
    send(8'h5A);
    chk("press btn0", {61'd0, btn_pulse}, 64'b001);

    left();
    send(8'h5A); send(8'h16);
    repeat (150) @(negedge clk);
`ifdef MENU_TIMEOUT_EN
    exp_after_idle = 1'b0;
`else
    exp_after_idle = 1'b1;
`endif
    chk("idle edit_active", {63'd0, edit_active}, {63'd0, exp_after_idle});
    chk("idle value kept", {44'd0, value_bcd}, 64'h10000);
    send(8'h76);

    foreach (tail[i]) send(tail[i]);
    chk("tail commit", {44'd0, value_bcd}, 64'h00097);
    left(); send(8'h5A);
    chk("press btn2", {61'd0, btn_pulse}, 64'b100);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/menu_selector.md
Name: menu_selector

Overview:
- Parametrised keyboard-driven menu controller for the VGA front panel.
- Consumes raw PS/2 set-2 scancode bytes and moves focus across N_BTN buttons plus one editable numeric field (sample time).
- Emits one-cycle press pulses per button and holds the committed field value in BCD and ASCII for the line renderers.
- Generalises the fixed 3-button selector: any button count, wrap-around navigation, and an in-place numeric edit mode.

Parameters:
- N_BTN, 3, number of push buttons; focus index N_BTN is the numeric field.
- DIGITS, 5, decimal digits in the numeric field.
- DEFAULT_BCD, 20'h10000, reset/committed value of the field, 4*DIGITS bits.
- TIMEOUT_CYCLES, 32'd800_000_000, edit idle timeout; used only with MENU_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- kb_valid  in  1  one-cycle strobe, kb_byte is a new scancode byte.
- kb_byte  in  8  raw scancode byte.
- focus  out  $clog2(N_BTN+1)  focused item index.
- btn_pulse  out  N_BTN  one-hot, one-cycle press pulse.
- edit_active  out  1  field is in edit mode.
- edit_bcd  out  4*DIGITS  shadow value shown while editing.
- value_bcd  out  4*DIGITS  committed value.
- value_ascii  out  8*DIGITS  committed value as ASCII, MSD first ("0"=8'h30).
- value_commit  out  1  one-cycle pulse on a successful commit.
- entry_error  out  1  one-cycle pulse on a rejected commit.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). All outputs are registered.
- Reset values: focus=0, btn_pulse=0, edit_active=0, value_bcd=edit_bcd=DEFAULT_BCD, value_ascii matches DEFAULT_BCD, commit/error pulses=0. rst wins over any same-cycle kb_valid and aborts an edit in progress.
- Decoder FSM, advancing only on kb_valid:
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte -> make event, return to IDLE.
  - EXT: F0 -> EXTBRK; other byte -> extended make event, return to IDLE.
  - BRK and EXTBRK: the next byte is consumed silently, return to IDLE.
  - Break codes never generate events. Typematic repeats generate repeated events.
- Key map:
  - Left = E0 6B; Right = E0 74; Enter = 5A; Esc = 76; Backspace = 66.
  - Digits 0-9 = 45,16,1E,26,25,2E,36,3D,3E,46.
  - Unmapped codes are ignored.
- Latency: an event's effect is visible on outputs in the cycle after kb_valid of the final byte. At most one event per cycle.
- Menu FSM, NAV state:
  - Left: focus-1, wrapping 0 -> N_BTN.
  - Right: focus+1, wrapping N_BTN -> 0.
  - Enter with focus<N_BTN: btn_pulse[focus]=1 for exactly one cycle.
  - Enter with focus==N_BTN: go to EDIT, edit_bcd <= value_bcd, edit_active=1.
  - Digits, Backspace and Esc are ignored.
- Menu FSM, EDIT state:
  - Digit d: edit_bcd <= {edit_bcd[4*DIGITS-5:0], d}; the MSD is discarded.
  - Backspace: edit_bcd <= {4'h0, edit_bcd[4*DIGITS-1:4]}.
  - Enter with edit_bcd!=0: value_bcd <= edit_bcd, value_commit pulse, return to NAV.
  - Enter with edit_bcd==0: entry_error pulse, remain in EDIT.
  - Esc: discard, edit_bcd <= value_bcd, return to NAV.
  - Left/Right are ignored; focus is held at N_BTN.
- value_ascii updates in the same cycle as value_bcd.
- btn_pulse is never asserted while edit_active=1.

Optional Feature:
- MENU_TIMEOUT_EN defined:
  - Counter clears on entry to EDIT and on every key event in EDIT.
  - Reaching TIMEOUT_CYCLES-1 aborts exactly as Esc: one cycle later edit_active=0 and edit_bcd=value_bcd.
  - Counter is held at 0 in NAV.
- MENU_TIMEOUT_EN undefined: no counter is built and EDIT persists indefinitely.

Decomposition:
- menu_pkg:
  - Scancode localparams (SC_E0, SC_F0, SC_LEFT, SC_RIGHT, SC_ENTER, SC_ESC, SC_BKSP, digit table).
  - Key-event enum (EV_NONE, EV_LEFT, EV_RIGHT, EV_ENTER, EV_ESC, EV_BKSP, EV_DIGIT).
  - Menu-state enum (NAV, EDIT).
- Sub-module ps2_key_decoder: prefix FSM plus key map; outputs ev_valid, ev_code, ev_digit[3:0].

Test Plan:
- Reset, then bytes E0 74 x4 with N_BTN=3 -> focus 1,2,3,0; E0 6B -> focus 3.
- focus=1, byte 5A -> btn_pulse=3'b010 for one cycle, next cycle 0; then F0 5A -> no pulse.
- focus=3, bytes 5A,16,1E,26,5A -> edit_active 1, edit_bcd 00001, 00012, 00123; value_bcd=20'h00123, value_ascii="00123", value_commit pulse, edit_active 0.
- EDIT with 00123: 66 x3, then 5A -> entry_error pulse, still EDIT; then 76 -> edit_bcd=00123, NAV.
- rst asserted mid-EDIT on the same cycle as kb_valid=16 -> all outputs at reset values; next byte treated from decoder IDLE.
- MENU_TIMEOUT_EN with TIMEOUT_CYCLES=100: enter EDIT, type 16, idle 100 cycles -> edit_active drops, value_bcd unchanged.
